// File: rtl/br_pred_track_queue.sv
// In-order tracking queue for in-flight branch predictions: captured at IF, checked at WB.
// A mispredicting resolve raises a registered one-cycle redirect/flush and empties the queue.
module br_pred_track_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [15:0]      push_pc,
    input  logic             push_pred_taken,
    input  logic [15:0]      push_pred_target,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    input  logic             pop,
    input  logic             actual_taken,
    input  logic [15:0]      actual_target,
    output logic             redirect_valid,
    output logic [15:0]      redirect_pc,
    output logic             flush,
    output logic             overflow_err,
    output logic             underflow_err,
    output logic [15:0]      branch_cnt,
    output logic [15:0]      mispred_cnt
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [15:0]      pc_mem     [DEPTH];
    logic             taken_mem  [DEPTH];
    logic [15:0]      target_mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [15:0]      redirect_pc_q, redirect_pc_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [15:0]      branch_cnt_q, branch_cnt_d;
    logic [15:0]      mispred_cnt_q, mispred_cnt_d;

    logic             pop_valid;
    logic             push_ok;
    logic             mispredict;
    logic [15:0]      head_pc;
    logic             head_taken;
    logic [15:0]      head_target;

    always_comb begin
        head_pc     = pc_mem[head_q];
        head_taken  = taken_mem[head_q];
        head_target = target_mem[head_q];

        pop_valid  = pop && (count_q != '0);
        mispredict = pop_valid && ((actual_taken != head_taken) ||
                                   (actual_taken && (actual_target != head_target)));
        // A push alongside a mispredicting pop is on the wrong path and is dropped.
        push_ok    = push && !mispredict && ((count_q != FULL_CNT) || pop_valid);

        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        redirect_valid_d = mispredict;
        redirect_pc_d    = redirect_pc_q;
        overflow_d       = overflow_q | (push && (count_q == FULL_CNT) && !pop);
        underflow_d      = underflow_q | (pop && (count_q == '0));
        branch_cnt_d     = branch_cnt_q;
        mispred_cnt_d    = mispred_cnt_q;

        if (pop_valid && (branch_cnt_q != 16'hFFFF)) begin
            branch_cnt_d = branch_cnt_q + 16'd1;
        end

        if (mispredict) begin
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            redirect_pc_d = actual_taken ? actual_target : (head_pc + 16'd2);
            if (mispred_cnt_q != 16'hFFFF) begin
                mispred_cnt_d = mispred_cnt_q + 16'd1;
            end
        end else begin
            if (pop_valid) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push_ok) begin
                tail_d = tail_q + PTR_W'(1);
            end
            case ({push_ok, pop_valid})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            overflow_q       <= 1'b0;
            underflow_q      <= 1'b0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            overflow_q       <= overflow_d;
            underflow_q      <= underflow_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
        end
    end

    // Entry payload is not reset; validity is tracked by head/tail/count alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem[tail_q]     <= push_pc;
            taken_mem[tail_q]  <= push_pred_taken;
            target_mem[tail_q] <= push_pred_target;
        end
    end

    assign full           = (count_q == FULL_CNT);
    assign empty          = (count_q == '0);
    assign count          = count_q;
    assign redirect_valid = redirect_valid_q;
    assign flush          = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign overflow_err   = overflow_q;
    assign underflow_err  = underflow_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_br_pred_track_queue.sv
// Self-checking bench for br_pred_track_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_br_pred_track_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             push;
    logic [15:0]      push_pc;
    logic             push_pred_taken;
    logic [15:0]      push_pred_target;
    logic             full;
    logic             empty;
    logic [PTR_W:0]   count;
    logic             pop;
    logic             actual_taken;
    logic [15:0]      actual_target;
    logic             redirect_valid;
    logic [15:0]      redirect_pc;
    logic             flush;
    logic             overflow_err;
    logic             underflow_err;
    logic [15:0]      branch_cnt;
    logic [15:0]      mispred_cnt;

    br_pred_track_queue #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .push             (push),
        .push_pc          (push_pc),
        .push_pred_taken  (push_pred_taken),
        .push_pred_target (push_pred_target),
        .full             (full),
        .empty            (empty),
        .count            (count),
        .pop              (pop),
        .actual_taken     (actual_taken),
        .actual_target    (actual_target),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .overflow_err     (overflow_err),
        .underflow_err    (underflow_err),
        .branch_cnt       (branch_cnt),
        .mispred_cnt      (mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        taken;
        logic [15:0] tgt;
    } ent_t;

    ent_t        mq[$];
    logic        m_rv;
    logic [15:0] m_rpc;
    logic        m_ovf;
    logic        m_unf;
    int          m_bcnt;
    int          m_mcnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rv   = 1'b0;
        m_rpc  = 16'h0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_bcnt = 0;
        m_mcnt = 0;
    endtask

    // One clock edge of behaviour, from the current inputs and queue contents.
    task automatic model_step();
        bit   pv;
        bit   mis;
        bit   acc;
        ent_t e;
        pv  = pop && (mq.size() > 0);
        mis = 1'b0;
        if (pv) begin
            mis = (actual_taken != mq[0].taken) || (actual_taken && (actual_target != mq[0].tgt));
        end
        if (push && (mq.size() == DEPTH) && !pop) m_ovf = 1'b1;
        if (pop && (mq.size() == 0)) m_unf = 1'b1;
        acc  = push && !mis && ((mq.size() < DEPTH) || pv);
        m_rv = mis;
        if (pv && (m_bcnt < 65535)) m_bcnt++;
        if (mis) begin
            m_rpc = actual_taken ? actual_target : 16'(mq[0].pc + 16'd2);
            if (m_mcnt < 65535) m_mcnt++;
            mq.delete();
        end else begin
            if (pv) void'(mq.pop_front());
            if (acc) begin
                e.pc    = push_pc;
                e.taken = push_pred_taken;
                e.tgt   = push_pred_target;
                mq.push_back(e);
            end
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    always @(posedge clk) begin
        if (chk_en) begin
            #1;
            check("count",          32'(count),          32'(mq.size()));
            check("full",           32'(full),           32'(mq.size() == DEPTH));
            check("empty",          32'(empty),          32'(mq.size() == 0));
            check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
            check("flush",          32'(flush),          32'(m_rv));
            check("redirect_pc",    32'(redirect_pc),    32'(m_rpc));
            check("overflow_err",   32'(overflow_err),   32'(m_ovf));
            check("underflow_err",  32'(underflow_err),  32'(m_unf));
            check("branch_cnt",     32'(branch_cnt),     32'(m_bcnt));
            check("mispred_cnt",    32'(mispred_cnt),    32'(m_mcnt));
        end
    end

    task automatic cyc(input logic ps, input logic [15:0] pc, input logic tk,
                       input logic [15:0] tg, input logic pp, input logic at,
                       input logic [15:0] atg);
        @(negedge clk);
        push             = ps;
        push_pc          = pc;
        push_pred_taken  = tk;
        push_pred_target = tg;
        pop              = pp;
        actual_taken     = at;
        actual_target    = atg;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        reset_n          = 1'b0;
        push             = 1'b0;
        push_pc          = '0;
        push_pred_taken  = 1'b0;
        push_pred_target = '0;
        pop              = 1'b0;
        actual_taken     = 1'b0;
        actual_target    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        check("rst_rpc",   32'(redirect_pc), 32'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Correct predictions, one taken and one not-taken.
        cyc(1'b1, 16'h3000, 1'b1, 16'h3020, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 16'h3010, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h3020);
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        check("ok_rv",    32'(redirect_valid), 32'd0);
        check("ok_bcnt",  32'(branch_cnt),     32'd2);
        check("ok_mcnt",  32'(mispred_cnt),    32'd0);
        check("ok_empty", 32'(empty),          32'd1);

        // Asynchronous reset with entries in flight.
        cyc(1'b1, 16'h1000, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 16'h1002, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 16'h1004, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        idle();
        check("pre_rst_count", 32'(count), 32'd3);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_count", 32'(count),          32'd0);
        check("arst_empty", 32'(empty),          32'd1);
        check("arst_rv",    32'(redirect_valid), 32'd0);
        check("arst_bcnt",  32'(branch_cnt),     32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Direction mispredict with two younger entries behind it.
        cyc(1'b1, 16'h4000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 16'h4002, 1'b1, 16'h4050, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 16'h4004, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h4100);
        check("dir_rv",    32'(redirect_valid), 32'd1);
        check("dir_flush", 32'(flush),          32'd1);
        check("dir_rpc",   32'(redirect_pc),    32'h4100);
        check("dir_count", 32'(count),          32'd0);
        check("dir_mcnt",  32'(mispred_cnt),    32'd1);
        idle();
        check("dir_rv_drop", 32'(redirect_valid), 32'd0);
        check("dir_rpc_hold", 32'(redirect_pc),   32'h4100);

        // Target mispredict, then taken-predicted but not-taken actual.
        cyc(1'b1, 16'h5000, 1'b1, 16'h5080, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h5090);
        check("tgt_rpc", 32'(redirect_pc), 32'h5090);
        idle();
        cyc(1'b1, 16'h6000, 1'b1, 16'h6040, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        check("nt_rpc",  32'(redirect_pc), 32'h6002);
        check("nt_mcnt", 32'(mispred_cnt), 32'd3);
        idle();

        // Fill, overflow, then pointer wrap with simultaneous push/pop.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 16'(16'h7000 + 2 * i), 1'b1, 16'(16'h7100 + i), 1'b0, 1'b0, 16'h0);
        end
        check("fill_full", 32'(full), 32'd1);
        cyc(1'b1, 16'hdead, 1'b1, 16'hbeef, 1'b0, 1'b0, 16'h0);
        check("ovf_count", 32'(count),        32'd4);
        check("ovf_err",   32'(overflow_err), 32'd1);
        for (int j = 0; j < 10; j++) begin
            cyc(1'b1, 16'(16'h7000 + 2 * (j + 4)), 1'b1, 16'(16'h7100 + j + 4),
                1'b1, 1'b1, 16'(16'h7100 + j));
            check("wrap_count", 32'(count),          32'd4);
            check("wrap_rv",    32'(redirect_valid), 32'd0);
        end
        for (int j = 10; j < 14; j++) begin
            cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'(16'h7100 + j));
            check("drain_rv", 32'(redirect_valid), 32'd0);
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Underflow, push+pop on empty, mispredict with simultaneous push.
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        check("unf_err",  32'(underflow_err), 32'd1);
        check("unf_bcnt", 32'(branch_cnt),    32'd17);
        cyc(1'b1, 16'h8000, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        check("pp_empty_count", 32'(count), 32'd1);
        cyc(1'b1, 16'h8002, 1'b0, 16'h0, 1'b1, 1'b1, 16'h8888);
        check("mp_push_count", 32'(count),       32'd0);
        check("mp_push_rpc",   32'(redirect_pc), 32'h8888);
        check("mp_push_mcnt",  32'(mispred_cnt), 32'd4);
        check("mp_push_bcnt",  32'(branch_cnt),  32'd18);

        // Randomized traffic; most pops resolve to the model's head prediction.
        for (int i = 0; i < 3000; i++) begin
            logic        ps;
            logic        pp;
            logic        at;
            logic [15:0] atg;
            ps  = ($urandom % 5) < 3;
            pp  = ($urandom % 2) == 0;
            at  = 1'($urandom);
            atg = 16'($urandom_range(0, 7));
            @(negedge clk);
            if (pp && (mq.size() > 0) && (($urandom % 4) != 0)) begin
                at  = mq[0].taken;
                atg = at ? mq[0].tgt : 16'($urandom);
            end
            cyc(ps, 16'($urandom), 1'($urandom), 16'($urandom_range(0, 7)), pp, at, atg);
        end
        idle();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
